operand_mux_bcd: RTL and testbench
==================================

Name: operand_mux_bcd

Overview:
- Datapath helper for the 8-bit teaching CPU.
- Combines the ALU operand-A multiplexer, the ALU operand-B multiplexer, and a binary-to-BCD converter of the ALU result.
- The BCD digits feed the seven-segment display scanner.
- All outputs are registered on a single clock; reset is synchronous.

Parameters:
- MUXB_K, 8'h01: constant driven on operand B when sel_b = 2'b11.

Ports:
- clk, input, 1: system clock, rising-edge active.
- rst, input, 1: synchronous reset, active-high.
- reg_a, input, 8: Register A contents.
- sel_a, input, 1: operand-A select.
- reg_b, input, 8: Register B contents.
- imm, input, 8: instruction immediate field, im[7:0].
- sel_b, input, 2: operand-B select.
- bin, input, 8: unsigned ALU result to convert.
- op_a, output, 8: registered operand A.
- op_b, output, 8: registered operand B.
- hundreds, output, 4: registered BCD hundreds digit, range 0..2.
- tens, output, 4: registered BCD tens digit, range 0..9.
- ones, output, 4: registered BCD ones digit, range 0..9.

Behaviour:
- Reset: on a rising clk edge with rst=1, op_a, op_b, hundreds, tens and ones all go to 0.
  - rst has priority over every input.
  - Asserting rst mid-stream discards the results computed in that cycle.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
  - No handshake; all three paths update every cycle.
- Operand A mux, registered into op_a:
  - sel_a=0 → reg_a.
  - sel_a=1 → 8'h00.
- Operand B mux, registered into op_b:
  - sel_b=00 → reg_b.
  - sel_b=01 → imm.
  - sel_b=10 → 8'h00.
  - sel_b=11 → MUXB_K.
- BCD path:
  - bin is treated as unsigned 0..255.
  - Conversion: hundreds = bin/100, tens = (bin/10)%10, ones = bin%10.
  - Implementation is combinational double-dabble (shift-add-3): 8 iterations; each BCD nibble ≥5 gets +3 before the shift.
  - The combinational result is then registered.
  - No invalid digit codes (≥10) may ever be produced.
- The three paths are independent. Simultaneous changes on all inputs are legal and take effect together on the next edge.
- Out-of-range inputs: none exist. Every select encoding is defined, and every 8-bit bin value is valid.
- Outputs hold their values while inputs are static.
- No X propagation from reset onward. Before the first reset, output values are don't-care.

Decomposition:
- Shared package operand_pkg:
  - Select encodings: SELA_REG=1'b0, SELA_ZERO=1'b1, SELB_REG=2'b00, SELB_IMM=2'b01, SELB_ZERO=2'b10, SELB_K=2'b11.
  - DATA_W=8.
  - BCD_W=4.
- One combinational sub-module bin2bcd8: 8-bit input; hundreds, tens and ones outputs; pure double-dabble logic.
- The top holds the mux logic and all output registers.

Test Plan:
- Reset: drive all inputs non-zero, rst=1 for one edge → op_a=0, op_b=0, hundreds=tens=ones=0. Then rst=0 → outputs track inputs after 1 edge.
- Mux A: reg_a=8'h5A; sel_a=0 → op_a=8'h5A. Set sel_a=1 → op_a=8'h00 on the next edge.
- Mux B sweep: reg_b=8'h33, imm=8'hC7, default MUXB_K; sel_b=00/01/10/11 on successive cycles → op_b = 33, C7, 00, 01, each one cycle late.
- BCD boundaries:
  - bin=0 → 0/0/0.
  - bin=9 → 0/0/9.
  - bin=10 → 0/1/0.
  - bin=99 → 0/9/9.
  - bin=100 → 1/0/0.
  - bin=255 → 2/5/5.
  - Exhaustive sweep 0..255: each output equals bin/100, (bin/10)%10, bin%10 one cycle later.
- Simultaneous change plus mid-stream reset: change sel_a, sel_b and bin in the same cycle → all outputs update on the same edge. Assert rst with bin=200 → digits read 0/0/0, not 2/0/0.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared widths and select encodings for the ALU operand muxes and BCD converter.
package operand_pkg;

   localparam int DATA_W = 8;
   localparam int BCD_W  = 4;

   typedef enum logic {
      SELA_REG  = 1'b0,
      SELA_ZERO = 1'b1
   } sel_a_t;

   typedef enum logic [1:0] {
      SELB_REG  = 2'b00,
      SELB_IMM  = 2'b01,
      SELB_ZERO = 2'b10,
      SELB_K    = 2'b11
   } sel_b_t;

endpackage

// File: rtl/bin2bcd8.sv
// Combinational 8-bit binary to three-digit BCD converter (shift-add-3).
module bin2bcd8
   import operand_pkg::*;
(
   input  logic [DATA_W-1:0] i_bin,
   output logic [BCD_W-1:0]  o_hundreds,
   output logic [BCD_W-1:0]  o_tens,
   output logic [BCD_W-1:0]  o_ones
);

   // Scratch layout: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary.
   logic [19:0] w_scratch;

   always_comb begin
      w_scratch = {12'd0, i_bin};
      for (int i = 0; i < DATA_W; i++) begin
         if (w_scratch[19:16] >= 4'd5) w_scratch[19:16] = w_scratch[19:16] + 4'd3;
         if (w_scratch[15:12] >= 4'd5) w_scratch[15:12] = w_scratch[15:12] + 4'd3;
         if (w_scratch[11:8]  >= 4'd5) w_scratch[11:8]  = w_scratch[11:8]  + 4'd3;
         w_scratch = w_scratch << 1;
      end
   end

   assign o_hundreds = w_scratch[19:16];
   assign o_tens     = w_scratch[15:12];
   assign o_ones     = w_scratch[11:8];

endmodule

// File: rtl/operand_mux_bcd.sv
// ALU operand-A/B multiplexers plus BCD conversion of the ALU result,
// all outputs registered with a one-cycle latency and synchronous reset.
module operand_mux_bcd
   import operand_pkg::*;
#(
   parameter logic [DATA_W-1:0] MUXB_K = 8'h01
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_reg_a,
   input  logic              i_sel_a,
   input  logic [DATA_W-1:0] i_reg_b,
   input  logic [DATA_W-1:0] i_imm,
   input  logic [1:0]        i_sel_b,
   input  logic [DATA_W-1:0] i_bin,
   output logic [DATA_W-1:0] o_op_a,
   output logic [DATA_W-1:0] o_op_b,
   output logic [BCD_W-1:0]  o_hundreds,
   output logic [BCD_W-1:0]  o_tens,
   output logic [BCD_W-1:0]  o_ones
);

   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [BCD_W-1:0]  w_hundreds;
   logic [BCD_W-1:0]  w_tens;
   logic [BCD_W-1:0]  w_ones;

   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic [BCD_W-1:0]  r_hundreds;
   logic [BCD_W-1:0]  r_tens;
   logic [BCD_W-1:0]  r_ones;

   always_comb begin
      w_op_a = i_reg_a;
      if (sel_a_t'(i_sel_a) == SELA_ZERO) w_op_a = '0;
   end

   always_comb begin
      w_op_b = i_reg_b;
      unique case (sel_b_t'(i_sel_b))
         SELB_REG:  w_op_b = i_reg_b;
         SELB_IMM:  w_op_b = i_imm;
         SELB_ZERO: w_op_b = '0;
         SELB_K:    w_op_b = MUXB_K;
         default:   w_op_b = i_reg_b;
      endcase
   end

   bin2bcd8 u_bin2bcd8 (
      .i_bin      (i_bin),
      .o_hundreds (w_hundreds),
      .o_tens     (w_tens),
      .o_ones     (w_ones)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_hundreds <= '0;
         r_tens     <= '0;
         r_ones     <= '0;
      end else begin
         r_op_a     <= w_op_a;
         r_op_b     <= w_op_b;
         r_hundreds <= w_hundreds;
         r_tens     <= w_tens;
         r_ones     <= w_ones;
      end
   end

   assign o_op_a     = r_op_a;
   assign o_op_b     = r_op_b;
   assign o_hundreds = r_hundreds;
   assign o_tens     = r_tens;
   assign o_ones     = r_ones;

endmodule

// File: tb/tb_operand_mux_bcd.sv
// Directed self-checking bench for operand_mux_bcd: reset, both muxes,
// BCD boundaries, a full BCD sweep, simultaneous changes and mid-stream reset.
module tb_operand_mux_bcd;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] reg_a, reg_b, imm, bin;
   logic       sel_a;
   logic [1:0] sel_b;
   logic [7:0] op_a, op_b;
   logic [3:0] hundreds, tens, ones;

   int checks = 0;
   int errors = 0;

   operand_mux_bcd #(.MUXB_K(8'h01)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_reg_a    (reg_a),
      .i_sel_a    (sel_a),
      .i_reg_b    (reg_b),
      .i_imm      (imm),
      .i_sel_b    (sel_b),
      .i_bin      (bin),
      .o_op_a     (op_a),
      .o_op_b     (op_b),
      .o_hundreds (hundreds),
      .o_tens     (tens),
      .o_ones     (ones)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; reg_a = 8'hA5; sel_a = 1'b0; reg_b = 8'h3C; imm = 8'hFF;
      sel_b = 2'b01; bin = 8'd255;
      tick();
      checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL reset_op_a: got %h expected 00", op_a); end
      checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL reset_op_b: got %h expected 00", op_b); end
      checks++; if ({hundreds, tens, ones} !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %0d/%0d/%0d expected 0/0/0", hundreds, tens, ones); end
      rst = 1'b0; sel_b = 2'b00; bin = 8'd137;
      tick();
      checks++; if (op_a !== 8'hA5) begin errors++; $display("FAIL post_reset_op_a: got %h expected a5", op_a); end
      checks++; if (op_b !== 8'h3C) begin errors++; $display("FAIL post_reset_op_b: got %h expected 3c", op_b); end
      checks++; if ({hundreds, tens, ones} !== 12'h137) begin errors++; $display("FAIL post_reset_bcd: got %0d/%0d/%0d expected 1/3/7", hundreds, tens, ones); end
   endtask

   task automatic test_mux_a();
      reg_a = 8'h5A; sel_a = 1'b0;
      tick();
      checks++; if (op_a !== 8'h5A) begin errors++; $display("FAIL mux_a_reg: got %h expected 5a", op_a); end
      sel_a = 1'b1;
      checks++; if (op_a !== 8'h5A) begin errors++; $display("FAIL mux_a_latency: got %h expected 5a", op_a); end
      tick();
      checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL mux_a_zero: got %h expected 00", op_a); end
   endtask

   task automatic test_mux_b();
      logic [1:0] sels [4];
      logic [7:0] exps [4];
      sels = '{2'b00, 2'b01, 2'b10, 2'b11};
      exps = '{8'h33, 8'hC7, 8'h00, 8'h01};
      reg_b = 8'h33; imm = 8'hC7;
      for (int i = 0; i < 4; i++) begin
         sel_b = sels[i];
         tick();
         checks++;
         if (op_b !== exps[i]) begin
            errors++; $display("FAIL mux_b_sel%0d: got %h expected %h", sels[i], op_b, exps[i]);
         end
      end
   endtask

   task automatic test_bcd_boundaries();
      logic [7:0]  vals [6];
      logic [11:0] exps [6];
      vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
      exps = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
      for (int i = 0; i < 6; i++) begin
         bin = vals[i];
         tick();
         checks++;
         if ({hundreds, tens, ones} !== exps[i]) begin
            errors++; $display("FAIL bcd_bound_%0d: got %0d/%0d/%0d expected %h", vals[i], hundreds, tens, ones, exps[i]);
         end
      end
   endtask

   task automatic test_bcd_sweep();
      int sweepErrs;
      sweepErrs = 0;
      for (int v = 0; v < 256; v++) begin
         bin = 8'(v);
         tick();
         checks++;
         if (hundreds !== 4'(v / 100) || tens !== 4'((v / 10) % 10) || ones !== 4'(v % 10)) begin
            errors++; sweepErrs++;
            if (sweepErrs <= 5)
               $display("FAIL bcd_sweep_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                        v, hundreds, tens, ones, v / 100, (v / 10) % 10, v % 10);
         end
      end
   endtask

   task automatic test_back_to_back();
      reg_a = 8'h5A; sel_a = 1'b0; reg_b = 8'h33; imm = 8'hC7; sel_b = 2'b00; bin = 8'd0;
      tick();
      sel_a = 1'b1; sel_b = 2'b01; bin = 8'd123;
      tick();
      checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL simul_op_a: got %h expected 00", op_a); end
      checks++; if (op_b !== 8'hC7) begin errors++; $display("FAIL simul_op_b: got %h expected c7", op_b); end
      checks++; if ({hundreds, tens, ones} !== 12'h123) begin errors++; $display("FAIL simul_bcd: got %0d/%0d/%0d expected 1/2/3", hundreds, tens, ones); end
      // A reset edge must discard the value presented in the same cycle.
      sel_a = 1'b0; sel_b = 2'b11; bin = 8'd200; rst = 1'b1;
      tick();
      checks++; if ({hundreds, tens, ones} !== 12'h000) begin errors++; $display("FAIL midreset_bcd: got %0d/%0d/%0d expected 0/0/0", hundreds, tens, ones); end
      checks++; if (op_a !== 8'h00 || op_b !== 8'h00) begin errors++; $display("FAIL midreset_ops: got %h/%h expected 00/00", op_a, op_b); end
      rst = 1'b0;
      tick();
      checks++; if ({hundreds, tens, ones} !== 12'h200) begin errors++; $display("FAIL after_midreset_bcd: got %0d/%0d/%0d expected 2/0/0", hundreds, tens, ones); end
      checks++; if (op_a !== 8'h5A || op_b !== 8'h01) begin errors++; $display("FAIL after_midreset_ops: got %h/%h expected 5a/01", op_a, op_b); end
      tick();
      checks++; if (op_a !== 8'h5A || op_b !== 8'h01 || {hundreds, tens, ones} !== 12'h200) begin errors++; $display("FAIL hold_static: got %h/%h/%0d%0d%0d expected 5a/01/200", op_a, op_b, hundreds, tens, ones); end
   endtask

   initial begin
      rst = 1'b1; reg_a = '0; sel_a = 1'b0; reg_b = '0; imm = '0; sel_b = 2'b00; bin = '0;
      #2;
      test_reset();
      test_mux_a();
      test_mux_b();
      test_bcd_boundaries();
      test_bcd_sweep();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
